asymmetric_fifo_pack: RTL and testbench

//   Narrow-in/wide-out FIFO: the packing counterpart of the wide-in/narrow-out unpacking FIFO.

---
 rtl/asymmetric_fifo_pack.sv | 114 +++++++++++
 tb/tb_asymmetric_fifo_pack.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/asymmetric_fifo_pack.sv
`default_nettype none
// ============================================================================
// Module      : asymmetric_fifo_pack
// Description : Narrow-in / wide-out packing FIFO. Each push writes one
//               WIDTH_IN-bit word into the next lane of the current wide row.
//               The oldest complete WIDTH_OUT-bit row is presented on q through
//               a combinational read. Lane order is little-endian: the first
//               narrow word of a row appears in q[WIDTH_IN-1:0].
// Ports       : clk, rst (sync, active high)
//               push, d           narrow write side
//               pop, q            wide read side (q valid while !empty)
//               full, empty, partial, count, almost_empty, almost_full
// Revision    : 1.0  initial release
// ============================================================================
module asymmetric_fifo_pack #(
    parameter int WIDTH_IN             = 8,
    parameter int WIDTH_OUT            = 64,
    parameter int DEPTH_OUT            = 32,
    parameter int DEPTH_IN_ADDR_WIDTH  = $clog2(DEPTH_OUT * (WIDTH_OUT / WIDTH_IN)),
    parameter int DEPTH_OUT_ADDR_WIDTH = $clog2(DEPTH_OUT),
    parameter int ALMOST_EMPTY_COUNT   = 1,
    parameter int ALMOST_FULL_COUNT    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH_IN-1:0]            d,
    output logic [WIDTH_OUT-1:0]           q,
    output logic                           full,
    output logic                           empty,
    output logic                           partial,
    output logic [DEPTH_IN_ADDR_WIDTH:0]   count,
    output logic                           almost_empty,
    output logic                           almost_full
);

    localparam int c_ratio      = WIDTH_OUT / WIDTH_IN;
    localparam int c_log2_ratio = $clog2(c_ratio);
    localparam int c_depth_in   = DEPTH_OUT * c_ratio;
    localparam int c_aw_in      = DEPTH_IN_ADDR_WIDTH;
    localparam int c_aw_out     = DEPTH_OUT_ADDR_WIDTH;
    localparam int c_cnt_w      = c_aw_in + 1;
    localparam int c_word_w     = c_cnt_w - c_log2_ratio;

    localparam logic [c_cnt_w-1:0]  c_full_cnt = c_cnt_w'(c_depth_in);
    localparam logic [c_cnt_w-1:0]  c_af_thr   = c_cnt_w'(c_depth_in - 1 - ALMOST_FULL_COUNT);
    localparam logic [c_word_w-1:0] c_ae_thr   = c_word_w'(1 + ALMOST_EMPTY_COUNT);

    // Pointers carry one extra wrap bit; write pointer counts narrow words,
    // read pointer counts wide words.
    logic [c_aw_in:0]  r_wr_ptr;
    logic [c_aw_out:0] r_rd_ptr;

    // Narrow-organised RAM: the low write-pointer bits address it directly,
    // so row = wr_ptr[AW_IN-1:LOG2_RATIO] and lane = wr_ptr[LOG2_RATIO-1:0].
    logic [WIDTH_IN-1:0] r_mem [c_depth_in];

    logic [c_cnt_w-1:0]  w_count;
    logic [c_word_w-1:0] w_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // RAM contents survive reset; only the pointers define valid data.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            r_mem[r_wr_ptr[c_aw_in-1:0]] <= d;
        end
    end

    // Wide asynchronous read: gather every lane of the row at the read pointer.
    generate
        for (genvar l = 0; l < c_ratio; l++) begin : g_lane
            assign q[l*WIDTH_IN +: WIDTH_IN] =
                r_mem[{r_rd_ptr[c_aw_out-1:0], c_log2_ratio'(l)}];
        end
    endgenerate

    // Modular subtraction keeps the count correct across pointer wrap.
    assign w_count      = r_wr_ptr - {r_rd_ptr, {c_log2_ratio{1'b0}}};
    assign w_words      = w_count[c_aw_in:c_log2_ratio];

    assign count        = w_count;
    assign empty        = (r_wr_ptr[c_aw_in:c_log2_ratio] == r_rd_ptr);
    assign full         = (w_count == c_full_cnt);
    assign partial      = |r_wr_ptr[c_log2_ratio-1:0];
    assign almost_empty = (w_words < c_ae_thr);
    assign almost_full  = (w_count > c_af_thr);

`ifndef SYNTHESIS
    // Protocol monitor: pointers are unguarded, so an overflow or underflow
    // corrupts the queue; stop simulation at the first occurrence.
    always_ff @(posedge clk) begin
        if (!rst && ((push && full) || (pop && empty))) begin
            $display("ERROR: %0t Overflow/underflow at %m", $time);
            $finish;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_asymmetric_fifo_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_asymmetric_fifo_pack
// Description : Self-checking bench for asymmetric_fifo_pack (8 -> 64 bit,
//               32 wide words). Reference model is a byte queue: count is its
//               size, a complete word is any group of 8 bytes at its head.
// Revision    : 1.0  initial release
// ============================================================================
module tb_asymmetric_fifo_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  d = '0;
    logic [63:0] q;
    logic        full, empty, partial, almost_empty, almost_full;
    logic [8:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq[$];

    asymmetric_fifo_pack #(
        .WIDTH_IN  (8),
        .WIDTH_OUT (64),
        .DEPTH_OUT (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .d            (d),
        .q            (q),
        .full         (full),
        .empty        (empty),
        .partial      (partial),
        .count        (count),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
    );

    always #5 clk = ~clk;

    // Oldest eight bytes packed little-endian.
    function automatic logic [63:0] model_word();
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < mq.size()) w[i*8 +: 8] = mq[i];
        end
        return w;
    endfunction

    // One clock: drive, advance model from pre-edge inputs, settle 1 time unit.
    task automatic tick(input logic p, input logic o, input logic [7:0] data);
        push = p;
        pop  = o;
        d    = data;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (o) begin
                for (int i = 0; i < 8; i++) void'(mq.pop_front());
            end
            if (p) mq.push_back(data);
        end
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'hAA);   // reset must win over a concurrent push
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 9'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
        n_checks++; if (partial !== 1'b0) $display("FAIL reset_partial: got %b expected 0", partial); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b expected 0", almost_full); else n_pass++;
    endtask

    task automatic test_pack();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 8'(i));
            n_checks++; if (empty !== (i < 8)) $display("FAIL pack_empty[%0d]: got %b expected %b", i, empty, (i < 8)); else n_pass++;
            n_checks++; if (partial !== (i < 8)) $display("FAIL pack_partial[%0d]: got %b expected %b", i, partial, (i < 8)); else n_pass++;
        end
        n_checks++; if (count !== 9'd8) $display("FAIL pack_count: got %0d expected 8", count); else n_pass++;
        n_checks++; if (q !== 64'h0807060504030201) $display("FAIL pack_q: got %h expected 0807060504030201", q); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL pack_almost_empty: got %b expected 1", almost_empty); else n_pass++;
    endtask

    task automatic test_fill();
        logic [63:0] exp_w;
        int sz;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 1'b0, 8'($urandom));
            sz = mq.size();
            n_checks++; if (count !== 9'(sz)) $display("FAIL fill_count: got %0d expected %0d", count, sz); else n_pass++;
            n_checks++; if (full !== (sz == 256)) $display("FAIL fill_full@%0d: got %b expected %b", sz, full, (sz == 256)); else n_pass++;
            n_checks++; if (almost_full !== (sz >= 255)) $display("FAIL fill_almost_full@%0d: got %b expected %b", sz, almost_full, (sz >= 255)); else n_pass++;
        end
        exp_w = model_word();
        n_checks++; if (q !== exp_w) $display("FAIL fill_q: got %h expected %h", q, exp_w); else n_pass++;
        tick(1'b0, 1'b1, 8'h00);
        n_checks++; if (full !== 1'b0) $display("FAIL fill_pop_full: got %b expected 0", full); else n_pass++;
        n_checks++; if (count !== 9'd248) $display("FAIL fill_pop_count: got %0d expected 248", count); else n_pass++;
        exp_w = model_word();
        n_checks++; if (q !== exp_w) $display("FAIL fill_pop_q: got %h expected %h", q, exp_w); else n_pass++;
    endtask

    task automatic test_stream();
        int sent = 0;
        int cyc  = 0;
        int sz;
        logic p, o;
        logic [63:0] exp_w;
        do_reset();
        while (sent < 1000 && cyc < 6000) begin
            p = (mq.size() < 256) && ($urandom_range(3) != 0);
            o = (mq.size() >= 8) && ($urandom_range(1) == 1);
            if (o) begin
                exp_w = model_word();
                n_checks++; if (q !== exp_w) $display("FAIL stream_q@%0d: got %h expected %h", cyc, q, exp_w); else n_pass++;
            end
            tick(p, o, 8'($urandom));
            if (p) sent++;
            cyc++;
            sz = mq.size();
            n_checks++; if (count !== 9'(sz)) $display("FAIL stream_count@%0d: got %0d expected %0d", cyc, count, sz); else n_pass++;
            n_checks++; if (empty !== (sz < 8)) $display("FAIL stream_empty@%0d: got %b expected %b", cyc, empty, (sz < 8)); else n_pass++;
            n_checks++; if (partial !== (sz % 8 != 0)) $display("FAIL stream_partial@%0d: got %b expected %b", cyc, partial, (sz % 8 != 0)); else n_pass++;
            n_checks++; if (almost_empty !== (sz / 8 < 2)) $display("FAIL stream_almost_empty@%0d: got %b expected %b", cyc, almost_empty, (sz / 8 < 2)); else n_pass++;
        end
        n_checks++; if (sent < 1000) $display("FAIL stream_budget: got %0d bytes expected 1000", sent); else n_pass++;
    endtask

    task automatic test_simul();
        logic [63:0] exp_w;
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 8'($urandom));
        n_checks++; if (count !== 9'd9) $display("FAIL simul_pre_count: got %0d expected 9", count); else n_pass++;
        exp_w = model_word();
        n_checks++; if (q !== exp_w) $display("FAIL simul_first_word: got %h expected %h", q, exp_w); else n_pass++;
        tick(1'b1, 1'b1, 8'($urandom));
        n_checks++; if (count !== 9'd2) $display("FAIL simul_count: got %0d expected 2", count); else n_pass++;
        n_checks++; if (partial !== 1'b1) $display("FAIL simul_partial: got %b expected 1", partial); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL simul_empty: got %b expected 1", empty); else n_pass++;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 8'($urandom));
        exp_w = model_word();
        n_checks++; if (q !== exp_w) $display("FAIL simul_second_word: got %h expected %h", q, exp_w); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [63:0] exp_w;
        do_reset();
        for (int i = 0; i < 13; i++) tick(1'b1, 1'b0, 8'($urandom));
        n_checks++; if (count !== 9'd13) $display("FAIL midrst_pre_count: got %0d expected 13", count); else n_pass++;
        do_reset();
        n_checks++; if (count !== 9'd0) $display("FAIL midrst_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty); else n_pass++;
        n_checks++; if (partial !== 1'b0) $display("FAIL midrst_partial: got %b expected 0", partial); else n_pass++;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'($urandom));
        exp_w = model_word();
        n_checks++; if (empty !== 1'b0) $display("FAIL midrst_after_empty: got %b expected 0", empty); else n_pass++;
        n_checks++; if (q !== exp_w) $display("FAIL midrst_q: got %h expected %h", q, exp_w); else n_pass++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_pack();
        test_fill();
        test_stream();
        test_simul();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
